// File: rtl/dm_cache_pkg.sv
// Shared types and geometry for the direct-mapped L1 data-cache controller.
// Address layout: {tag, index, byte offset}; one line is 2**S_OFFSET bytes.
package dm_cache_pkg;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  localparam int ADDR_W   = 32;
  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int LINE_W   = 8 << S_OFFSET;
  localparam int BE_W     = 1 << S_OFFSET;

  function automatic int tag_width(input int s_offset, input int s_index);
    return ADDR_W - s_offset - s_index;
  endfunction

endpackage

// File: rtl/dm_cache_control_if.sv
// Bus bundle around the cache controller: CPU line port, physical-memory port and data-array port.
// The controller connects through `master`; the surrounding cache top / environment uses `slave`.
interface dm_cache_control_if
  import dm_cache_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_index  = S_INDEX
);

  localparam int LW = 8 << s_offset;
  localparam int BW = 1 << s_offset;

  logic                mem_read;
  logic                mem_write;
  logic [ADDR_W-1:0]   mem_address;
  logic [BW-1:0]       mem_byte_enable256;
  logic [LW-1:0]       mem_wdata256;
  logic [LW-1:0]       mem_rdata256;
  logic                mem_resp;

  logic                pmem_read;
  logic                pmem_write;
  logic [ADDR_W-1:0]   pmem_address;
  logic [LW-1:0]       pmem_wdata;
  logic [LW-1:0]       pmem_rdata;
  logic                pmem_resp;

  logic                da_read;
  logic [s_index-1:0]  da_rindex;
  logic [s_index-1:0]  da_windex;
  logic [BW-1:0]       da_write_en;
  logic [LW-1:0]       da_datain;
  logic [LW-1:0]       da_dataout;

  modport master (
    input  mem_read, mem_write, mem_address, mem_byte_enable256, mem_wdata256,
    input  pmem_rdata, pmem_resp, da_dataout,
    output mem_rdata256, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output da_read, da_rindex, da_windex, da_write_en, da_datain
  );

  modport slave (
    output mem_read, mem_write, mem_address, mem_byte_enable256, mem_wdata256,
    output pmem_rdata, pmem_resp, da_dataout,
    input  mem_rdata256, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  da_read, da_rindex, da_windex, da_write_en, da_datain
  );

endinterface

// File: rtl/dm_meta_array.sv
// Per-set tag/valid/dirty storage: combinational read, write on the rising edge.
// Valid and dirty clear on reset; tags are left unreset since valid gates their use.
module dm_meta_array
  import dm_cache_pkg::*;
#(
  parameter int s_index = S_INDEX,
  parameter int s_tag   = ADDR_W - S_OFFSET - S_INDEX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_index-1:0] rindex_i,
  input  logic [s_index-1:0] windex_i,
  input  logic               load_i,
  input  logic               set_dirty_i,
  input  logic [s_tag-1:0]   wtag_i,
  output logic [s_tag-1:0]   tag_o,
  output logic               valid_o,
  output logic               dirty_o
);

  localparam int NSETS = 1 << s_index;

  logic [s_tag-1:0] tag_q [NSETS];
  logic [NSETS-1:0] valid_q, valid_d;
  logic [NSETS-1:0] dirty_q, dirty_d;

  for (genvar gi = 0; gi < NSETS; gi++) begin : g_set
    logic sel;
    assign sel = (windex_i == s_index'(gi));
    assign valid_d[gi] = valid_q[gi] | (load_i & sel);
    // A fresh line is always clean, even if a dirty mark is requested the same cycle.
    assign dirty_d[gi] = (load_i & sel) ? 1'b0 : (dirty_q[gi] | (set_dirty_i & sel));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      tag_q[windex_i] <= wtag_i;
    end
  end

  assign tag_o   = tag_q[rindex_i];
  assign valid_o = valid_q[rindex_i];
  assign dirty_o = dirty_q[rindex_i];

endmodule

// File: rtl/dm_cache_control.sv
// Direct-mapped L1 data-cache sequencer: hit check, dirty write-back and line fill.
// Owns the metadata; the line-wide data array lives beside it in the cache top.
module dm_cache_control
  import dm_cache_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_index  = S_INDEX
) (
  input logic              clk,
  input logic              rst,
  dm_cache_control_if.master bus
);

  localparam int s_tag = ADDR_W - s_offset - s_index;
  localparam int LW    = 8 << s_offset;
  localparam int BW    = 1 << s_offset;

  logic [s_tag-1:0]   addr_tag;
  logic [s_index-1:0] addr_idx;
  logic               unused_offset_bits;

  assign addr_tag = bus.mem_address[ADDR_W-1 -: s_tag];
  assign addr_idx = bus.mem_address[s_offset +: s_index];
  assign unused_offset_bits = ^bus.mem_address[s_offset-1:0];

  logic [s_tag-1:0] meta_tag;
  logic             meta_valid;
  logic             meta_dirty;
  logic             meta_load;
  logic             meta_set_dirty;

  dm_meta_array #(
    .s_index (s_index),
    .s_tag   (s_tag)
  ) u_meta (
    .clk         (clk),
    .rst         (rst),
    .rindex_i    (addr_idx),
    .windex_i    (addr_idx),
    .load_i      (meta_load),
    .set_dirty_i (meta_set_dirty),
    .wtag_i      (addr_tag),
    .tag_o       (meta_tag),
    .valid_o     (meta_valid),
    .dirty_o     (meta_dirty)
  );

  state_e state_q, state_d;

  logic              req;
  logic              hit;
  logic              mem_resp_c;
  logic              pmem_read_c;
  logic              pmem_write_c;
  logic [ADDR_W-1:0] pmem_addr_c;
  logic [BW-1:0]     da_we_c;
  logic [LW-1:0]     da_din_c;

  assign req = bus.mem_read | bus.mem_write;
  assign hit = meta_valid && (meta_tag == addr_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CHECK;
    end else begin
      state_q <= state_d;
    end
  end

  // Everything is held idle during reset so a late pmem_resp cannot commit a fill.
  always_comb begin
    state_d        = state_q;
    mem_resp_c     = 1'b0;
    pmem_read_c    = 1'b0;
    pmem_write_c   = 1'b0;
    pmem_addr_c    = '0;
    da_we_c        = '0;
    da_din_c       = '0;
    meta_load      = 1'b0;
    meta_set_dirty = 1'b0;
    if (!rst) begin
      case (state_q)
        CHECK: begin
          if (req) begin
            if (hit) begin
              mem_resp_c = 1'b1;
              if (bus.mem_write) begin
                da_we_c        = bus.mem_byte_enable256;
                da_din_c       = bus.mem_wdata256;
                meta_set_dirty = 1'b1;
              end
            end else if (meta_valid && meta_dirty) begin
              state_d = WRITEBACK;
            end else begin
              state_d = FILL;
            end
          end
        end
        WRITEBACK: begin
          pmem_write_c = 1'b1;
          pmem_addr_c  = {meta_tag, addr_idx, {s_offset{1'b0}}};
          if (bus.pmem_resp) begin
            state_d = FILL;
          end
        end
        FILL: begin
          pmem_read_c = 1'b1;
          pmem_addr_c = {addr_tag, addr_idx, {s_offset{1'b0}}};
          if (bus.pmem_resp) begin
            da_we_c   = '1;
            da_din_c  = bus.pmem_rdata;
            meta_load = 1'b1;
            state_d   = CHECK;
          end
        end
        default: state_d = CHECK;
      endcase
    end
  end

  assign bus.mem_resp     = mem_resp_c;
  assign bus.mem_rdata256 = bus.da_dataout;
  assign bus.pmem_read    = pmem_read_c;
  assign bus.pmem_write   = pmem_write_c;
  assign bus.pmem_address = pmem_addr_c;
  assign bus.pmem_wdata   = bus.da_dataout;
  assign bus.da_read      = 1'b1;
  assign bus.da_rindex    = addr_idx;
  assign bus.da_windex    = addr_idx;
  assign bus.da_write_en  = da_we_c;
  assign bus.da_datain    = da_din_c;

endmodule

// File: tb/tb_dm_cache_control.sv
// Self-checking bench for dm_cache_control: directed scenarios then random line traffic
// against a memory-level reference (CPU-visible lines plus which line each set holds).
module tb_dm_cache_control;

  localparam int NS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_cache_control_if #(.s_offset(5), .s_index(3)) bus ();

  dm_cache_control #(.s_offset(5), .s_index(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line-wide data array with write bypass on the read port
  logic [255:0] da_mem [NS] = '{default: '0};

  always_comb begin
    bus.da_dataout = da_mem[bus.da_rindex];
    for (int b = 0; b < 32; b++) begin
      if (bus.da_write_en[b] && bus.da_windex == bus.da_rindex)
        bus.da_dataout[8*b +: 8] = bus.da_datain[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < 32; b++) begin
      if (bus.da_write_en[b]) da_mem[bus.da_windex][8*b +: 8] <= bus.da_datain[8*b +: 8];
    end
  end

  // Physical memory and reference model
  logic [255:0] pmem_mem [logic [31:0]];
  logic [255:0] ref_mem  [logic [31:0]];
  bit           res_valid [NS];
  bit           res_dirty [NS];
  logic [31:0]  res_line  [NS];

  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    if (a == 32'h40) return {32{8'hA5}};
    for (int b = 0; b < 32; b++) l[8*b +: 8] = (a[12:5] * 8'd29 + 8'(b * 7) + a[31:24]) ^ 8'h5A;
    return l;
  endfunction

  function automatic logic [255:0] pmem_get(input logic [31:0] a);
    if (pmem_mem.exists(a)) return pmem_mem[a];
    return init_line(a);
  endfunction

  function automatic logic [255:0] ref_get(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           cyc;
  } op_t;

  op_t          ops_log [$];
  bit           auto_on = 1'b1;
  logic         auto_resp = 1'b0;
  logic [255:0] auto_rdata = '0;
  logic         man_resp = 1'b0;
  logic [255:0] man_rdata = '0;

  assign bus.pmem_resp  = auto_on ? auto_resp  : man_resp;
  assign bus.pmem_rdata = auto_on ? auto_rdata : man_rdata;

  // Memory responder: random 1..4 cycle latency, logs each completed transaction
  initial begin
    bit  active;
    int  cnt;
    op_t cur;
    active = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      auto_resp = 1'b0;
      if (!auto_on || rst) begin
        active = 0;
        continue;
      end
      if (!active && (bus.pmem_read || bus.pmem_write)) begin
        active   = 1;
        cur.wr   = bus.pmem_write;
        cur.addr = bus.pmem_address;
        cur.data = bus.pmem_wdata;
        cur.cyc  = 0;
        cnt      = $urandom_range(0, 3);
      end
      if (active) begin
        check_val("pmem_hold", 256'({bus.pmem_read, bus.pmem_write, bus.pmem_address}),
                  256'({!cur.wr, cur.wr, cur.addr}));
        cur.cyc++;
        if (cnt == 0) begin
          auto_resp = 1'b1;
          if (cur.wr) pmem_mem[cur.addr] = cur.data;
          else        auto_rdata = pmem_get(cur.addr);
          ops_log.push_back(cur);
          active = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // One CPU transaction; entered and left just after a rising edge
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] be, input logic [255:0] wd);
    logic [31:0]  line;
    logic [255:0] l;
    logic [255:0] rdata;
    int  idx, cycles, exp_cyc;
    bit  hit, got;
    op_t e;
    op_t exp_q [$];
    line = {addr[31:5], 5'b0};
    idx  = int'(addr[7:5]);
    hit  = res_valid[idx] && res_line[idx] == line;
    if (!hit) begin
      if (res_valid[idx] && res_dirty[idx]) begin
        e.wr = 1; e.addr = res_line[idx]; e.data = ref_get(res_line[idx]); e.cyc = 0;
        exp_q.push_back(e);
      end
      e.wr = 0; e.addr = line; e.data = '0; e.cyc = 0;
      exp_q.push_back(e);
    end
    ops_log.delete();
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.mem_address = addr;
    bus.mem_byte_enable256 = be;
    bus.mem_wdata256 = wd;
    cycles = 0;
    got = 0;
    rdata = '0;
    while (!got && cycles < 64) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) check_val("da_rindex", 256'(bus.da_rindex), 256'(addr[7:5]));
      if (bus.mem_resp) begin
        got = 1;
        rdata = bus.mem_rdata256;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    check_val("resp_seen", 256'(got), 256'(1));
    check_val("op_count", 256'(ops_log.size()), 256'(exp_q.size()));
    exp_cyc = hit ? 1 : 2;
    for (int i = 0; i < exp_q.size() && i < ops_log.size(); i++) begin
      check_val("op_kind", 256'(ops_log[i].wr), 256'(exp_q[i].wr));
      check_val("op_addr", 256'(ops_log[i].addr), 256'(exp_q[i].addr));
      if (exp_q[i].wr) check_val("wb_data", ops_log[i].data, exp_q[i].data);
      exp_cyc += ops_log[i].cyc;
    end
    check_val("latency", 256'(cycles), 256'(exp_cyc));
    if (rd && !wr) check_val("rdata", rdata, ref_get(line));
    if (!hit) begin
      res_valid[idx] = 1;
      res_line[idx]  = line;
      res_dirty[idx] = 0;
    end
    if (wr) begin
      l = ref_get(line);
      for (int b = 0; b < 32; b++) if (be[b]) l[8*b +: 8] = wd[8*b +: 8];
      ref_mem[line]  = l;
      res_dirty[idx] = 1;
    end
    $display("txn rd=%0d wr=%0d addr=%h %s ops=%0d cycles=%0d", rd, wr, addr,
             hit ? "hit " : "miss", ops_log.size(), cycles);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    case ($urandom_range(0, 3))
      0: base = 32'h0000_0000;
      1: base = 32'h0000_0100;
      2: base = 32'h8000_0200;
      default: base = 32'hFFFF_FF00;
    endcase
    return base | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [255:0] wd;
    logic [255:0] rnd;
    int kind;
    rst = 1'b1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.mem_byte_enable256 = '0;
    bus.mem_wdata256 = '0;
    for (int i = 0; i < NS; i++) begin
      res_valid[i] = 0; res_dirty[i] = 0; res_line[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_pmem_read", 256'(bus.pmem_read), 256'(0));
    check_val("rst_da_read", 256'(bus.da_read), 256'(1));
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_mem_resp", 256'(bus.mem_resp), 256'(0));
    check_val("idle_pmem_rw", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
    check_val("idle_pmem_addr", 256'(bus.pmem_address), 256'(0));
    check_val("idle_da_we", 256'(bus.da_write_en), 256'(0));
    check_val("idle_da_read", 256'(bus.da_read), 256'(1));
    @(posedge clk);
    #1;

    // Clean miss fill, write hit, read-back, dirty eviction, read+write treated as write
    do_txn(1, 0, 32'h0000_0040, 32'h0, '0);
    wd = {32{8'hEE}};
    wd[7:0] = 8'h3C;
    do_txn(0, 1, 32'h0000_0040, 32'h0000_0001, wd);
    do_txn(1, 0, 32'h0000_0040, 32'h0, '0);
    check_val("byte0_merge", ref_get(32'h40), {{31{8'hA5}}, 8'h3C});
    do_txn(1, 0, 32'h0000_0140, 32'h0, '0);
    check_val("wb_landed", pmem_get(32'h40), {{31{8'hA5}}, 8'h3C});
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_txn(1, 1, 32'h0000_0140, 32'h0000_00F0, rnd);
    do_txn(1, 0, 32'h0000_0140, 32'h0, '0);

    // Spurious pmem_resp while idle
    auto_on = 1'b0;
    man_rdata = {32{8'hFF}};
    man_resp = 1'b1;
    @(negedge clk);
    check_val("spur_mem_resp", 256'(bus.mem_resp), 256'(0));
    check_val("spur_pmem_rw", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
    check_val("spur_da_we", 256'(bus.da_write_en), 256'(0));
    @(posedge clk);
    #1;
    man_resp = 1'b0;
    @(negedge clk);
    check_val("spur_after_rw", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
    @(posedge clk);
    #1;
    auto_on = 1'b1;
    do_txn(1, 0, 32'h0000_0140, 32'h0, '0);

    // Reset in the middle of a fill, with a response landing in the reset cycle
    auto_on = 1'b0;
    bus.mem_read = 1'b1;
    bus.mem_address = 32'h0000_2000;
    @(negedge clk);
    check_val("rst_t_miss_rd", 256'(bus.pmem_read), 256'(0));
    check_val("rst_t_miss_resp", 256'(bus.mem_resp), 256'(0));
    @(negedge clk);
    check_val("rst_t_fill_rd", 256'(bus.pmem_read), 256'(1));
    check_val("rst_t_fill_addr", 256'(bus.pmem_address), 256'(32'h0000_2000));
    rst = 1'b1;
    man_resp = 1'b1;
    bus.mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    man_resp = 1'b0;
    #1;
    check_val("rst_t_drop", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
    check_val("rst_t_resp", 256'(bus.mem_resp), 256'(0));
    check_val("rst_t_nowrite", da_mem[0], 256'(0));
    for (int i = 0; i < NS; i++) begin
      res_valid[i] = 0; res_dirty[i] = 0;
    end
    ref_mem.delete();
    foreach (pmem_mem[k]) ref_mem[k] = pmem_mem[k];
    @(posedge clk);
    #1;
    auto_on = 1'b1;
    do_txn(1, 0, 32'h0000_0040, 32'h0, '0);
    do_txn(1, 0, 32'h0000_2000, 32'h0, '0);

    // Random traffic over four tags and all eight sets
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 3);
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_txn(kind != 2, kind >= 2, rand_addr(), $urandom, rnd);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
